quotient_bcd_encoder: RTL and testbench

QUOTIENT_BCD_ENCODER -- requirements
Module: quotient_bcd_encoder

---
 rtl/quotient_bcd_encoder.sv | 141 ++++++++++++++
 tb/tb_quotient_bcd_encoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/quotient_bcd_encoder.sv
// Serial MSB-first binary quotient to excess-3 decimal digits.
// Collects QW bits, runs sequential double-dabble, then emits ND digits most significant first.
module quotient_bcd_encoder #(
    parameter int QW = 10,
    parameter int ND = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       out_valid,
    output logic [3:0] out_data
);

    localparam int CNT_MAX = (QW > ND) ? QW : ND;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = 4 * ND;

    localparam logic [CW-1:0] LAST_BIT = CW'(QW - 1);
    localparam logic [CW-1:0] LAST_DIG = CW'(ND - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CONVERT = 2'd2,
        EMIT    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      out_data_q, out_data_d;
    logic [BW-1:0]   bcd_adj;

    // Add 3 to every nibble >= 5 so that the following left shift carries correctly into the next decade.
    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] bcd);
        logic [BW-1:0] adj;
        adj = bcd;
        for (int i = 0; i < ND; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

    function automatic logic [3:0] excess3(input logic [3:0] digit);
        return digit + 4'd3;
    endfunction

    assign bcd_adj = dabble_adjust(bcd_q);

    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        out_valid_d = 1'b0;
        out_data_d  = 4'b0000;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // First bit lands at the LSB and reaches bit QW-1 after the remaining QW-1 shifts.
                    quo_d   = {{(QW-1){1'b0}}, in_data};
                    cnt_d   = CW'(1);
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (in_valid) begin
                    quo_d = {quo_q[QW-2:0], in_data};
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        bcd_d   = '0;
                        state_d = CONVERT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            CONVERT: begin
                bcd_d = (bcd_adj << 1) | BW'(quo_q[QW-1]);
                quo_d = quo_q << 1;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            EMIT: begin
                out_valid_d = 1'b1;
                out_data_d  = excess3(bcd_q[BW-1 -: 4]);
                bcd_d       = bcd_q << 4;
                if (cnt_q == LAST_DIG) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            quo_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 4'b0000;
        end else begin
            state_q     <= state_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_quotient_bcd_encoder.sv
// Directed bench for quotient_bcd_encoder: vector table plus abort, back-to-back, hold and reset sequences.
module tb_quotient_bcd_encoder;

    localparam int QW  = 10;
    localparam int ND  = 4;
    localparam int LAT = QW + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_data = 1'b0;
    logic       out_valid;
    logic [3:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [QW-1:0] q;
        logic [15:0]   digits;
    } vec_t;

    vec_t vecs[10];

    quotient_bcd_encoder #(.QW(QW), .ND(ND)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame MSB first; returns #1 after the edge that samples bit 0.
    task automatic send_frame(input logic [QW-1:0] q, input bit hold);
        for (int i = QW - 1; i >= 0; i--) begin
            in_valid = 1'b1;
            in_data  = q[i];
            @(posedge clk);
            #1;
        end
        in_valid = hold;
        in_data  = hold;
    endtask

    task automatic expect_burst(input string name, input logic [15:0] digits);
        int  k;
        bit  got;
        got = 1'b0;
        for (k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({name, " burst seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, " latency"}, 32'(k), 32'(LAT));
            for (int d = 0; d < ND; d++) begin
                if (d > 0) begin
                    @(posedge clk);
                    #1;
                end
                check($sformatf("%s valid%0d", name, d), 32'(out_valid), 32'd1);
                check($sformatf("%s digit%0d", name, d), 32'(out_data), 32'(digits[15-4*d -: 4]));
            end
        end
    endtask

    task automatic expect_idle_after(input string name);
        @(posedge clk);
        #1;
        check({name, " valid low"}, 32'(out_valid), 32'd0);
        check({name, " data zero"}, 32'(out_data), 32'd0);
    endtask

    task automatic expect_quiet(input string name, input int n);
        int pulses;
        pulses = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (out_valid || (out_data != 4'd0)) pulses++;
        end
        check({name, " quiet"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        vecs[0] = '{10'd767,  16'h3A9A};
        vecs[1] = '{10'd1023, 16'h4356};
        vecs[2] = '{10'd0,    16'h3333};
        vecs[3] = '{10'd5,    16'h3338};
        vecs[4] = '{10'd42,   16'h3375};
        vecs[5] = '{10'd999,  16'h3CCC};
        vecs[6] = '{10'd1000, 16'h4333};
        vecs[7] = '{10'd509,  16'h383C};
        vecs[8] = '{10'd1,    16'h3334};
        vecs[9] = '{10'd512,  16'h3845};

        repeat (2) @(posedge clk);
        #1;
        check("reset valid", 32'(out_valid), 32'd0);
        check("reset data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        // First frame starts on the very first edge after reset release.
        for (int v = 0; v < 10; v++) begin
            send_frame(vecs[v].q, 1'b0);
            expect_burst($sformatf("vec%0d(%0d)", v, vecs[v].q), vecs[v].digits);
            expect_idle_after($sformatf("vec%0d", v));
        end

        // Partial frame of 6 bits, then a gap, then a full frame of 5.
        for (int i = QW - 1; i >= QW - 6; i--) begin
            in_valid = 1'b1;
            in_data  = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 1'b0;
        @(posedge clk);
        #1;
        send_frame(10'd5, 1'b0);
        expect_burst("abort", 16'h3338);
        expect_quiet("abort extra", 20);

        // Second frame begins on the edge right after the last digit is loaded.
        send_frame(10'd42, 1'b0);
        expect_burst("b2b 42", 16'h3375);
        send_frame(10'd999, 1'b0);
        expect_burst("b2b 999", 16'h3CCC);
        expect_idle_after("b2b");

        // in_valid stays high through conversion and emission.
        send_frame(10'd767, 1'b1);
        expect_burst("hold", 16'h3A9A);
        in_valid = 1'b0;
        in_data  = 1'b0;
        expect_idle_after("hold");
        expect_quiet("hold extra", 5);

        // Reset pulse while the second digit is on the output.
        send_frame(10'd767, 1'b0);
        repeat (LAT) @(posedge clk);
        #1;
        check("rst emit d0 valid", 32'(out_valid), 32'd1);
        check("rst emit d0 data", 32'(out_data), 32'h3);
        @(posedge clk);
        #1;
        check("rst emit d1 data", 32'(out_data), 32'hA);
        rst_n = 1'b0;
        #1;
        check("rst emit async valid", 32'(out_valid), 32'd0);
        check("rst emit async data", 32'(out_data), 32'd0);
        #2;
        rst_n = 1'b1;
        expect_quiet("rst emit rest", 20);
        send_frame(10'd1023, 1'b0);
        expect_burst("post rst emit", 16'h4356);
        expect_idle_after("post rst emit");

        // Reset in the middle of conversion.
        send_frame(10'd1000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_quiet("rst convert", 20);
        send_frame(10'd0, 1'b0);
        expect_burst("post rst convert", 16'h3333);
        expect_idle_after("post rst convert");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
